// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned W x W -> 2W multiplier that borrows the execute-stage ALU
// for its additions (ADD) and carry detection (GEQ); shifts and muxing stay local.
module alu_mul_sequencer #(
   parameter int              W      = 8,
   parameter int              Ops    = 4,
   parameter logic [Ops-1:0]  OP_ADD = Ops'(0),
   parameter logic [Ops-1:0]  OP_GEQ = Ops'(9)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [W-1:0]       MulA,
   input  logic [W-1:0]       MulB,
   output logic               Ready,
   output logic               Done,
   output logic [2*W-1:0]     Product,
   output logic [W-1:0]       ALU_A,
   output logic [W-1:0]       ALU_B,
   output logic [Ops-1:0]     ALU_OP,
   input  logic [W-1:0]       ALU_Out
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADD   = 3'd1,
      S_CARRY = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [W-1:0]       r_m;
   logic [W-1:0]       r_phi;
   logic [W-1:0]       r_plo;
   logic [W-1:0]       r_sum;
   logic [CW-1:0]      r_cnt;
   logic               r_carry;
   logic [2*W-1:0]     r_product;

   logic [W-1:0]       w_phi_shift;
   logic [W-1:0]       w_plo_shift;
   logic               w_accept;
   logic               w_last;

   assign Ready    = (r_state == S_IDLE) || (r_state == S_DONE);
   assign Done     = (r_state == S_DONE);
   assign Product  = r_product;
   assign w_accept = Ready && Start;
   assign w_last   = (r_cnt == LAST_CNT);

   // r_carry is only ever set by a CARRY cycle, so a bit that skipped the add shifts in 0.
   assign w_phi_shift = {r_carry, r_phi[W-1:1]};
   assign w_plo_shift = {r_phi[0], r_plo[W-1:1]};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state   <= S_IDLE;
         r_m       <= '0;
         r_phi     <= '0;
         r_plo     <= '0;
         r_sum     <= '0;
         r_cnt     <= '0;
         r_carry   <= 1'b0;
         r_product <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_m     <= MulA;
                  r_phi   <= '0;
                  r_plo   <= MulB;
                  r_cnt   <= '0;
                  r_carry <= 1'b0;
               end
            end
            S_ADD: begin
               r_sum <= ALU_Out;
            end
            S_CARRY: begin
               r_phi   <= r_sum;
               r_carry <= ~ALU_Out[0];
            end
            S_SHIFT: begin
               r_phi   <= w_phi_shift;
               r_plo   <= w_plo_shift;
               r_cnt   <= r_cnt + CW'(1);
               r_carry <= 1'b0;
               // Load the result on the way into DONE so it is valid while Done is high.
               if (w_last) begin
                  r_product <= {w_phi_shift, w_plo_shift};
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      ALU_A        = '0;
      ALU_B        = '0;
      ALU_OP       = OP_ADD;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               w_state_next = MulB[0] ? S_ADD : S_SHIFT;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_ADD: begin
            ALU_A        = r_phi;
            ALU_B        = r_m;
            ALU_OP       = OP_ADD;
            w_state_next = S_CARRY;
         end
         S_CARRY: begin
            ALU_A        = r_sum;
            ALU_B        = r_phi;
            ALU_OP       = OP_GEQ;
            w_state_next = S_SHIFT;
         end
         S_SHIFT: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = r_plo[1] ? S_ADD : S_SHIFT;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random checks of alu_mul_sequencer paired with a behavioural ALU
// that implements ADD (wrapping) and GEQ (Out[0] = A >= B).
module tb_alu_mul_sequencer;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_GEQ = 4'h9;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  mul_a = '0;
   logic [7:0]  mul_b = '0;
   logic        ready;
   logic        done;
   logic [15:0] product;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_op;
   logic [7:0]  alu_out;

   int n_vec  = 0;
   int n_miss = 0;
   int n_add, n_carry, n_geq, n_carry0;
   int n_bad_op = 0;
   int lat;

   always #5 clk = ~clk;

   alu_mul_sequencer #(.W(8), .Ops(4), .OP_ADD(OP_ADD), .OP_GEQ(OP_GEQ)) dut (
      .Clk     (clk),
      .Reset   (rst_n),
      .Start   (start),
      .MulA    (mul_a),
      .MulB    (mul_b),
      .Ready   (ready),
      .Done    (done),
      .Product (product),
      .ALU_A   (alu_a),
      .ALU_B   (alu_b),
      .ALU_OP  (alu_op),
      .ALU_Out (alu_out)
   );

   always_comb begin
      alu_out = '0;
      if (alu_op == OP_ADD) alu_out = 8'(alu_a + alu_b);
      else if (alu_op == OP_GEQ) alu_out = {7'd0, (alu_a >= alu_b)};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle bus bookkeeping, sampled mid-cycle.
   task automatic observe_bus();
      if (alu_op == OP_ADD && alu_b != 8'd0) n_add++;
      if (alu_op == OP_GEQ) begin
         n_geq++;
         n_carry++;
         if (alu_out[0] == 1'b0) n_carry0++;
      end
      if (alu_op != OP_ADD && alu_op != OP_GEQ) n_bad_op++;
   endtask

   // Issue one multiply and wait (bounded) for Done; lat stays 0 on timeout.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start = 1'b1;
      mul_a = a;
      mul_b = b;
      n_add = 0; n_carry = 0; n_geq = 0; n_carry0 = 0; lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         observe_bus();
         if (done) begin
            lat = c;
            break;
         end
      end
      $display("op 0x%02h*0x%02h -> product 0x%04h latency %0d", a, b, product, lat);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'h0);
      check("rst_alu_a", 32'(alu_a), 32'h0);
      check("rst_alu_b", 32'(alu_b), 32'h0);
      check("rst_alu_op", 32'(alu_op), 32'(OP_ADD));
      rst_n = 1'b1;

      // 1: zero multiplier
      run_op(8'h07, 8'h00);
      check("t1_latency", 32'(lat), 32'd9);
      check("t1_product", 32'(product), 32'h0000);
      check("t1_no_geq", 32'(n_geq), 32'd0);
      @(negedge clk);
      check("t1_done_pulse", 32'(done), 32'd0);

      // 2: 12*10
      run_op(8'h0C, 8'h0A);
      check("t2_latency", 32'(lat), 32'd13);
      check("t2_product", 32'(product), 32'h0078);
      check("t2_add_cycles", 32'(n_add), 32'd2);
      check("t2_carry_cycles", 32'(n_carry), 32'd2);

      // 3: full-scale, exercises the carry path
      run_op(8'hFF, 8'hFF);
      check("t3_latency", 32'(lat), 32'd25);
      check("t3_product", 32'(product), 32'hFE01);
      check("t3_carry_seen", 32'(n_carry0 != 0), 32'd1);

      // 4: Start held during busy op is ignored; Start in DONE is accepted
      @(negedge clk);
      start = 1'b1; mul_a = 8'h0C; mul_b = 8'h0A; lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
         mul_a = 8'h55; mul_b = 8'hAA;
      end
      $display("op 0x0c*0x0a (start held) -> product 0x%04h latency %0d", product, lat);
      check("t4_first_latency", 32'(lat), 32'd13);
      check("t4_first_product", 32'(product), 32'h0078);
      mul_a = 8'h03; mul_b = 8'h05;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) check("t4_done_single", 32'(done), 32'd0);
         if (done) begin
            lat = c;
            break;
         end
      end
      $display("op 0x03*0x05 (back-to-back) -> product 0x%04h latency %0d", product, lat);
      check("t4_second_latency", 32'(lat), 32'd13);
      check("t4_second_product", 32'(product), 32'h000F);
      @(negedge clk);
      check("t4_done_drop", 32'(done), 32'd0);

      // 5: asynchronous reset mid-operation
      @(negedge clk);
      start = 1'b1; mul_a = 8'hFF; mul_b = 8'hFF;
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("t5_busy", 32'(ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("t5_ready", 32'(ready), 32'd1);
      check("t5_done", 32'(done), 32'd0);
      check("t5_product", 32'(product), 32'h0);
      check("t5_alu_op", 32'(alu_op), 32'(OP_ADD));
      $display("async reset mid-op -> ready %0d done %0d product 0x%04h", ready, done, product);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h02, 8'h03);
      check("t5_after_latency", 32'(lat), 32'd13);
      check("t5_after_product", 32'(product), 32'h0006);

      // 6: random pairs against a*b
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] a, b;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         run_op(a, b);
         check("rand_product", 32'(product), 32'(16'(a) * 16'(b)));
         check("rand_latency", 32'(lat), 32'(9 + 2 * $countones(b)));
      end
      check("alu_op_legal", 32'(n_bad_op), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
